time_date_counter: RTL and testbench
====================================

TIME_DATE_COUNTER -- requirements
Module: time_date_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, giving the number of clk cycles per second tick.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port model, input, 2, the mode: 00 clock, 01 alarm, 10 stopwatch, 11 adjust.
REQ-005 SHALL have port date_time_ch, input, 1, the adjust target select (0 time, 1 date); it gates the load per REQ-013.
REQ-006 SHALL have port adjust_time_num, input, 24, the adjusted time as BCD HH_MM_SS.
REQ-007 SHALL have port adjust_date_num, input, 24, the adjusted date as BCD YY_MM_DD.
REQ-008 SHALL have port time_num, output, 24, the current time as BCD HH_MM_SS, registered.
REQ-009 SHALL have port data_num, output, 24, the current date as BCD YY_MM_DD, registered.
REQ-010 SHALL have port sec_pulse, output, 1, a one-cycle pulse coincident with each time_num advance.

Function
REQ-011 SHALL run a prescaler 0..TICK_DIV-1; the cycle it holds TICK_DIV-1 is a tick.
- The prescaler wraps to 0 after a tick.
- time_num advances by 1 s on the clock edge ending that cycle.
- sec_pulse is high during the first cycle the new value is visible.
REQ-012 SHALL, while model==11, hold the prescaler at 0, suppress ticks, and keep time_num and data_num frozen.
REQ-013 SHALL load on the first cycle model changes from 11 to any other value (exit edge, using a registered model_d).
- Load adjust_time_num when date_time_ch==0.
- Load adjust_date_num when date_time_ch==1.
- The load takes effect one cycle later.
- The prescaler restarts from 0.
- No sec_pulse is produced by a load.
REQ-014 SHALL sanitise loaded fields:
- second or minute > 59 -> 00;
- hour > 23 -> 00;
- month 00 or > 12 -> 01;
- day 00 -> 01;
- day > days_in_month -> days_in_month;
- any nibble > 9 is treated as field-invalid and set to the field's minimum.
REQ-015 SHALL perform all arithmetic in BCD; no binary intermediate is exposed on any output.
REQ-016 SHALL cascade time roll-overs in a single edge: SS 59->00 carries to MM, MM 59->00 carries to HH, HH 23->00 carries to date.
REQ-017 SHALL increment the date on the HH carry:
- DD at month length -> 01, and MM increments;
- MM 12 -> 01, and YY increments;
- YY 99 -> 00.
REQ-018 SHALL use month lengths 31/28/31/30/31/30/31/31/30/31/30/31 for months 01..12, with February modified per REQ-022.
REQ-019 SHALL give a load priority over a tick when both fall in the same cycle; the tick is discarded.
REQ-020 SHALL ignore date_time_ch and the adjust inputs at all times other than the exit-edge cycle.

Reset
REQ-021 SHALL, while rst is high at a clock edge, set outputs and internal state as follows, with rst taking priority over load and tick:
- time_num = 24'h00_00_00;
- data_num = 24'h20_01_01;
- sec_pulse = 0;
- prescaler = 0;
- model_d = 00.

Configuration
REQ-022 SHALL support macro LEAP_YEAR_EN.
- When defined: February has 29 days when YY is divisible by 4 (YY 00 counts as leap), and REQ-014 clamps against 29.
- When undefined: February is always 28 days, and 29 is clamped to 28.

Structure
REQ-023 SHALL place the following in shared package clock_pkg:
- MODE_CLOCK/ALARM/STOPWATCH/ADJUST constants;
- BCD field-width typedefs;
- RST_TIME/RST_DATE constants;
- a days_in_month(mm, yy) function honouring LEAP_YEAR_EN.
REQ-024 SHALL instantiate sub-module bcd_wrap_counter for each field (SS, MM, HH, DD, MO, YY).
- Each instance is a 2-digit BCD counter.
- Inputs: inc, load, load value, min, max.
- Outputs: value and carry.

Verification (TICK_DIV=4)
REQ-025 SHALL verify reset: assert rst for one cycle -> time_num=00_00_00, data_num=20_01_01, sec_pulse=0.
REQ-026 SHALL verify day roll-over: load time 23_59_58 and date 20_06_30 via 11->00 exits -> after 2 ticks time=00_00_00 and date=20_07_01, with exactly one sec_pulse per tick.
REQ-027 SHALL verify year and leap handling:
- date 99_12_31 with time 23_59_59 -> one tick gives 00_01_01;
- date 24_02_28 at day roll-over -> 24_02_29 with LEAP_YEAR_EN, 24_03_01 without.
REQ-028 SHALL verify adjust hold: model=11 held for 40 cycles -> no sec_pulse and outputs unchanged; exit with date_time_ch=0 and adjust_time_num=15_26_01 -> time_num=15_26_01 one cycle later, data_num unchanged.
REQ-029 SHALL verify sanitisation: load date 21_02_31 -> data_num=21_02_28; load time 25_61_5A -> time_num=00_00_00.
REQ-030 SHALL verify collisions: a load exit coincident with a tick -> the loaded value is shown, no sec_pulse, and the next advance occurs TICK_DIV cycles later; rst during a roll-over cycle -> reset values win.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared mode encodings, BCD field types, reset values and calendar helpers
// for the time/date counter. Define LEAP_YEAR_EN to enable 29-day leap Februaries.
package clock_pkg;

    localparam logic [1:0] MODE_CLOCK     = 2'b00;
    localparam logic [1:0] MODE_ALARM     = 2'b01;
    localparam logic [1:0] MODE_STOPWATCH = 2'b10;
    localparam logic [1:0] MODE_ADJUST    = 2'b11;

    typedef logic [7:0]  bcd2_t;
    typedef logic [23:0] bcd6_t;

    localparam bcd6_t RST_TIME = 24'h00_00_00;
    localparam bcd6_t RST_DATE = 24'h20_01_01;

    function automatic bcd2_t days_in_month(bcd2_t mm, bcd2_t yy);
        bcd2_t days;
        logic  leap;
        // BCD year divisible by 4: even tens with ones 0/4/8, odd tens with ones 2/6
        leap = yy[4] ? (yy[3:0] == 4'd2 || yy[3:0] == 4'd6)
                     : (yy[3:0] == 4'd0 || yy[3:0] == 4'd4 || yy[3:0] == 4'd8);
        case (mm)
            8'h04, 8'h06, 8'h09, 8'h11: days = 8'h30;
            8'h02: begin
`ifdef LEAP_YEAR_EN
                days = leap ? 8'h29 : 8'h28;
`else
                days = (leap & 1'b0) ? 8'h29 : 8'h28;
`endif
            end
            default: days = 8'h31;
        endcase
        return days;
    endfunction

    // Invalid digits or values below lo fall to lo; above hi either clamp to hi or fall to lo.
    function automatic bcd2_t bcd_sanitize(bcd2_t v, bcd2_t lo, bcd2_t hi, logic clamp_high);
        bcd2_t r;
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) r = lo;
        else if (v < lo)                   r = lo;
        else if (v > hi)                   r = clamp_high ? hi : lo;
        else                               r = v;
        return r;
    endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter wrapping max -> min, with a sanitised parallel load
// and a same-cycle carry for cascading into the next field.
module bcd_wrap_counter
    import clock_pkg::*;
#(
    parameter bcd2_t RST_VAL    = 8'h00,
    parameter bit    CLAMP_HIGH = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic [7:0] min,
    input  logic [7:0] max,
    output logic [7:0] value,
    output logic       carry
);

    assign carry = inc && (value >= max);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= RST_VAL;
        end else if (load) begin
            value <= bcd_sanitize(load_value, min, max, CLAMP_HIGH);
        end else if (inc) begin
            if (value >= max)              value <= min;
            else if (value[3:0] == 4'd9)   value <= {value[7:4] + 4'd1, 4'd0};
            else                           value <= value + 8'd1;
        end
    end

endmodule

// File: rtl/time_date_counter.sv
// BCD time-of-day and calendar counter advanced by a prescaled second tick,
// loaded from the adjust inputs on leaving adjust mode. LEAP_YEAR_EN selects leap Februaries.
module time_date_counter
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  model,
    input  logic        date_time_ch,
    input  logic [23:0] adjust_time_num,
    input  logic [23:0] adjust_date_num,
    output logic [23:0] time_num,
    output logic [23:0] data_num,
    output logic        sec_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [1:0]    model_d;
    logic          adj_exit, load_time, load_date, tick;
    logic          ss_c, mm_c, hh_c, dd_c, mo_c, yy_carry_unused;
    bcd2_t         ss, mm, hh, dd, mo, yy, dd_max;

    assign adj_exit  = (model_d == MODE_ADJUST) && (model != MODE_ADJUST);
    assign load_time = adj_exit && !date_time_ch;
    assign load_date = adj_exit && date_time_ch;
    // A load always wins over a coincident tick
    assign tick      = (model != MODE_ADJUST) && !adj_exit && (prescaler == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            model_d   <= MODE_CLOCK;
            sec_pulse <= 1'b0;
        end else begin
            model_d   <= model;
            sec_pulse <= tick;
            if (model == MODE_ADJUST || adj_exit || prescaler == PRE_LAST)
                prescaler <= '0;
            else
                prescaler <= prescaler + 1'b1;
        end
    end

    // Day limit follows the month/year being loaded, otherwise the current month/year
    always_comb begin
        dd_max = days_in_month(mo, yy);
        if (load_date)
            dd_max = days_in_month(bcd_sanitize(adjust_date_num[15:8], 8'h01, 8'h12, 1'b0),
                                   bcd_sanitize(adjust_date_num[23:16], 8'h00, 8'h99, 1'b0));
    end

    bcd_wrap_counter #(.RST_VAL(RST_TIME[7:0]), .CLAMP_HIGH(1'b0)) u_ss (
        .clk(clk), .rst(rst), .inc(tick), .load(load_time),
        .load_value(adjust_time_num[7:0]), .min(8'h00), .max(8'h59),
        .value(ss), .carry(ss_c));

    bcd_wrap_counter #(.RST_VAL(RST_TIME[15:8]), .CLAMP_HIGH(1'b0)) u_mm (
        .clk(clk), .rst(rst), .inc(ss_c), .load(load_time),
        .load_value(adjust_time_num[15:8]), .min(8'h00), .max(8'h59),
        .value(mm), .carry(mm_c));

    bcd_wrap_counter #(.RST_VAL(RST_TIME[23:16]), .CLAMP_HIGH(1'b0)) u_hh (
        .clk(clk), .rst(rst), .inc(mm_c), .load(load_time),
        .load_value(adjust_time_num[23:16]), .min(8'h00), .max(8'h23),
        .value(hh), .carry(hh_c));

    bcd_wrap_counter #(.RST_VAL(RST_DATE[7:0]), .CLAMP_HIGH(1'b1)) u_dd (
        .clk(clk), .rst(rst), .inc(hh_c), .load(load_date),
        .load_value(adjust_date_num[7:0]), .min(8'h01), .max(dd_max),
        .value(dd), .carry(dd_c));

    bcd_wrap_counter #(.RST_VAL(RST_DATE[15:8]), .CLAMP_HIGH(1'b0)) u_mo (
        .clk(clk), .rst(rst), .inc(dd_c), .load(load_date),
        .load_value(adjust_date_num[15:8]), .min(8'h01), .max(8'h12),
        .value(mo), .carry(mo_c));

    bcd_wrap_counter #(.RST_VAL(RST_DATE[23:16]), .CLAMP_HIGH(1'b0)) u_yy (
        .clk(clk), .rst(rst), .inc(mo_c), .load(load_date),
        .load_value(adjust_date_num[23:16]), .min(8'h00), .max(8'h99),
        .value(yy), .carry(yy_carry_unused));

    assign time_num = {hh, mm, ss};
    assign data_num = {yy, mo, dd};

endmodule

// File: tb/tb_time_date_counter.sv
// Randomised and directed bench for time_date_counter against an integer calendar model.
module tb_time_date_counter;

    localparam int TD = 4;
`ifdef LEAP_YEAR_EN
    localparam logic [23:0] LEAP_EXP = 24'h24_02_29;
`else
    localparam logic [23:0] LEAP_EXP = 24'h24_03_01;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  model = 2'b00;
    logic        date_time_ch = 1'b0;
    logic [23:0] adjust_time_num = '0;
    logic [23:0] adjust_date_num = '0;
    logic [23:0] time_num, data_num;
    logic        sec_pulse;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    time_date_counter #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .model(model), .date_time_ch(date_time_ch),
        .adjust_time_num(adjust_time_num), .adjust_date_num(adjust_date_num),
        .time_num(time_num), .data_num(data_num), .sec_pulse(sec_pulse));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (plain integer calendar) ----------------
    int m_h, m_mi, m_s, m_y, m_mo, m_d, m_pc, m_md;
    bit m_pulse;

    function automatic int dim(int mo, int y);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        int r = t[mo - 1];
`ifdef LEAP_YEAR_EN
        if (mo == 2 && y % 4 == 0) r = 29;
`endif
        return r;
    endfunction

    function automatic int fld(logic [7:0] b);
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    always @(posedge clk) begin
        bit ex, tk;
        int dm;
        if (rst) begin
            m_h = 0; m_mi = 0; m_s = 0; m_y = 20; m_mo = 1; m_d = 1;
            m_pc = 0; m_md = 0; m_pulse = 0;
        end else begin
            ex = (m_md == 3) && (model != 2'd3);
            tk = (model != 2'd3) && !ex && (m_pc == TD - 1);
            m_pulse = tk;
            if (ex && !date_time_ch) begin
                m_h  = fld(adjust_time_num[23:16]); if (m_h < 0 || m_h > 23) m_h = 0;
                m_mi = fld(adjust_time_num[15:8]);  if (m_mi < 0 || m_mi > 59) m_mi = 0;
                m_s  = fld(adjust_time_num[7:0]);   if (m_s < 0 || m_s > 59) m_s = 0;
            end else if (ex) begin
                m_y  = fld(adjust_date_num[23:16]); if (m_y < 0) m_y = 0;
                m_mo = fld(adjust_date_num[15:8]);  if (m_mo < 1 || m_mo > 12) m_mo = 1;
                m_d  = fld(adjust_date_num[7:0]);   dm = dim(m_mo, m_y);
                if (m_d < 1) m_d = 1; else if (m_d > dm) m_d = dm;
            end else if (tk) begin
                m_s++;
                if (m_s == 60) begin
                    m_s = 0; m_mi++;
                    if (m_mi == 60) begin
                        m_mi = 0; m_h++;
                        if (m_h == 24) begin
                            m_h = 0; m_d++;
                            if (m_d > dim(m_mo, m_y)) begin
                                m_d = 1; m_mo++;
                                if (m_mo > 12) begin m_mo = 1; m_y = (m_y + 1) % 100; end
                            end
                        end
                    end
                end
            end
            m_pc = (model == 2'd3 || ex || m_pc == TD - 1) ? 0 : m_pc + 1;
            m_md = int'(model);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("time", time_num, {to_bcd(m_h), to_bcd(m_mi), to_bcd(m_s)});
            chk("date", data_num, {to_bcd(m_y), to_bcd(m_mo), to_bcd(m_d)});
            chk("pulse", {23'd0, sec_pulse}, {23'd0, m_pulse});
        end
    end

    // ---------------- stimulus helpers ----------------
    // Enter adjust, exit with the given target; returns in the first cycle the load is visible.
    task automatic do_load(input logic sel, input logic [23:0] v);
        @(negedge clk); model = 2'b11;
        repeat (3) @(negedge clk);
        date_time_ch = sel;
        if (sel) adjust_date_num = v; else adjust_time_num = v;
        model = 2'(($urandom_range(0, 2)));
        @(negedge clk);
        adjust_time_num = 24'($urandom);
        adjust_date_num = 24'($urandom);
        date_time_ch    = 1'($urandom);
    endtask

    task automatic run_count(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (sec_pulse) pulses++;
        end
    endtask

    function automatic logic [23:0] rand_time();
        case ($urandom_range(0, 3))
            0:       return 24'($urandom);
            1:       return {to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)),
                             to_bcd($urandom_range(0, 59))};
            default: return {8'h23, 8'h59, to_bcd($urandom_range(50, 59))};
        endcase
    endfunction

    function automatic logic [23:0] rand_date();
        case ($urandom_range(0, 3))
            0:       return 24'($urandom);
            1:       return {to_bcd($urandom_range(0, 99)), to_bcd($urandom_range(1, 12)),
                             to_bcd($urandom_range(1, 31))};
            2:       return {to_bcd($urandom_range(0, 99)), 8'h02, to_bcd($urandom_range(27, 31))};
            default: return {to_bcd($urandom_range(0, 99)), 8'h12, 8'h31};
        endcase
    endfunction

    initial begin
        int p;
        int delay;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_time", time_num, 24'h00_00_00);
        chk("rst_date", data_num, 24'h20_01_01);
        chk("rst_pulse", {23'd0, sec_pulse}, 24'd0);
        rst = 1'b0;

        // day roll-over
        do_load(1'b1, 24'h20_06_30);
        do_load(1'b0, 24'h23_59_58);
        run_count(2 * TD, p);
        chk("day_time", time_num, 24'h00_00_00);
        chk("day_date", data_num, 24'h20_07_01);
        chk("day_pulses", 24'(p), 24'd2);

        // year wrap
        do_load(1'b1, 24'h99_12_31);
        do_load(1'b0, 24'h23_59_59);
        run_count(TD, p);
        chk("year_date", data_num, 24'h00_01_01);
        chk("year_time", time_num, 24'h00_00_00);

        // February 28 roll-over
        do_load(1'b1, 24'h24_02_28);
        do_load(1'b0, 24'h23_59_59);
        run_count(TD, p);
        chk("leap_date", data_num, LEAP_EXP);

        // sanitisation
        do_load(1'b1, 24'h21_02_31);
        chk("san_date", data_num, 24'h21_02_28);
        do_load(1'b0, 24'h25_61_5A);
        chk("san_time", time_num, 24'h00_00_00);

        // adjust hold
        @(negedge clk); model = 2'b11;
        run_count(40, p);
        chk("hold_pulses", 24'(p), 24'd0);
        date_time_ch = 1'b0; adjust_time_num = 24'h15_26_01; model = 2'b00;
        @(negedge clk);
        chk("hold_time", time_num, 24'h15_26_01);
        chk("hold_date", data_num, 24'h21_02_28);

        // load then next advance TD cycles later
        do_load(1'b0, 24'h10_20_30);
        chk("coll_pulse", {23'd0, sec_pulse}, 24'd0);
        chk("coll_time", time_num, 24'h10_20_30);
        delay = 0;
        for (int i = 1; i <= 3 * TD; i++) begin
            @(negedge clk);
            if (sec_pulse) begin delay = i; break; end
        end
        chk("coll_delay", 24'(delay), 24'(TD));
        chk("coll_next", time_num, 24'h10_20_31);

        // reset in a roll-over cycle
        do_load(1'b1, 24'h20_12_31);
        do_load(1'b0, 24'h23_59_59);
        model = 2'b00;
        repeat (TD - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstroll_time", time_num, 24'h00_00_00);
        chk("rstroll_date", data_num, 24'h20_01_01);
        chk("rstroll_pulse", {23'd0, sec_pulse}, 24'd0);
        rst = 1'b0;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) model = 2'($urandom);
            date_time_ch    = 1'($urandom);
            adjust_time_num = rand_time();
            adjust_date_num = rand_date();
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
